// File: rtl/modular_multiplier_serial_if.sv
// rtl/modular_multiplier_serial_if.sv - start/operand/result handshake bundle for the serial modular multiplier
interface modular_multiplier_serial_if #(
    parameter int WIDTH = 256
);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;

    modport slave (
        input  i_start,
        input  i_a,
        input  i_b,
        output result,
        output done,
        output busy
    );

    modport master (
        output i_start,
        output i_a,
        output i_b,
        input  result,
        input  done,
        input  busy
    );
endinterface

// File: rtl/modular_multiplier_serial.sv
// rtl/modular_multiplier_serial.sv - bit-serial interleaved (a*b) mod P, one multiplier bit per cycle, MSB first
module modular_multiplier_serial #(
    parameter int               WIDTH = 256,
    parameter logic [WIDTH-1:0] P     = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    modular_multiplier_serial_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH:0] P_EXT = {1'b0, P};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_r;
    logic [CW-1:0]    r_cnt;
    logic             r_start_q;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic             r_busy;

    logic             w_start_pulse;
    logic [WIDTH:0]   w_t;
    logic [WIDTH:0]   w_tp;
    logic [WIDTH:0]   w_u;
    logic [WIDTH:0]   w_s;
    logic [WIDTH-1:0] w_next;

    assign w_start_pulse = bus.i_start & ~r_start_q;

    // Datapath kept at WIDTH+1 bits so the carry out of 2R and T'+A is never lost.
    // T' < P already, so the shared final reduction is a no-op on the B[i]=0 path.
    always_comb begin
        w_t    = {r_r, 1'b0};
        w_tp   = (w_t >= P_EXT) ? (w_t - P_EXT) : w_t;
        w_u    = w_tp + {1'b0, r_a};
        w_s    = r_b[r_cnt] ? w_u : w_tp;
        w_next = (w_s >= P_EXT) ? WIDTH'(w_s - P_EXT) : WIDTH'(w_s);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_r       <= '0;
            r_cnt     <= '0;
            r_start_q <= 1'b0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_start_q <= bus.i_start;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_pulse) begin
                        r_a     <= bus.i_a;
                        r_b     <= bus.i_b;
                        r_r     <= '0;
                        r_cnt   <= CW'(WIDTH - 1);
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_r <= w_next;
                    if (r_cnt == '0) begin
                        r_result <= w_next;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.done   = r_done;
    assign bus.busy   = r_busy;
endmodule

// File: tb/tb_modular_multiplier_serial.sv
// tb/tb_modular_multiplier_serial.sv - directed and random checks of the serial modular multiplier
module tb_modular_multiplier_serial;
    localparam logic [255:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    modular_multiplier_serial_if #(.WIDTH(256)) bus ();

    modular_multiplier_serial #(.WIDTH(256), .P(P)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] ref_mul(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] x, y, m;
        x = {256'b0, a};
        y = {256'b0, b};
        m = {256'b0, P};
        return 256'((x * y) % m);
    endfunction

    function automatic logic [255:0] rand_fe();
        logic [255:0] v;
        logic [511:0] w, m;
        v = '0;
        for (int k = 0; k < 8; k++) v = {v[223:0], 32'($urandom())};
        w = {256'b0, v};
        m = {256'b0, P};
        return 256'(w % m);
    endfunction

    task automatic chk(input logic [255:0] obs, input logic [255:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launches an operation at a negedge and counts edges until done.
    task automatic run_op(input logic [255:0] a, input logic [255:0] b,
                          input int hold_edges, input int inj_edge,
                          input logic [255:0] ia, input logic [255:0] ib,
                          output int edges, output int busy_cycles, output logic done_e1);
        edges       = 0;
        busy_cycles = 0;
        done_e1     = 1'bx;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_start = 1'b1;
        while (1) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) done_e1 = bus.done;
            if (edges == hold_edges) bus.i_start = 1'b0;
            if (edges == inj_edge) begin
                bus.i_a     = ia;
                bus.i_b     = ib;
                bus.i_start = 1'b1;
            end
            if (edges == inj_edge + 1) bus.i_start = 1'b0;
            if (bus.done === 1'b1) break;
            if (bus.busy === 1'b1) busy_cycles++;
            if (edges >= 400) break;
        end
        bus.i_start = 1'b0;
    endtask

    task automatic full_op(input logic [255:0] a, input logic [255:0] b, input string tag);
        int   e, bc;
        logic d1;
        run_op(a, b, 1, -10, '0, '0, e, bc, d1);
        chk(256'(e), 256'd257, {tag, "_latency"});
        chk(bus.result, ref_mul(a, b), {tag, "_result"});
        chk(256'(d1), 256'd0, {tag, "_done_clear"});
        chk(256'(bc), 256'd256, {tag, "_busy_cycles"});
        chk(256'(bus.busy), 256'd0, {tag, "_busy_end"});
    endtask

    initial begin
        int           e, bc;
        logic         d1;
        logic         stable;
        logic [255:0] a1, b1, a2, b2;
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        #1;
        chk(bus.result, 256'd0, "reset_result");
        chk(256'(bus.done), 256'd0, "reset_done");
        chk(256'(bus.busy), 256'd0, "reset_busy");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        full_op(256'd2, 256'd3, "basic");
        chk(bus.result, 256'd6, "basic_const");
        @(negedge clk);
        full_op(P - 256'd1, P - 256'd1, "neg1_sq");
        chk(bus.result, 256'd1, "neg1_sq_const");
        @(negedge clk);
        full_op(256'd1 << 255, 256'd2, "wrap");
        chk(bus.result, 256'h1000003D1, "wrap_const");
        @(negedge clk);
        full_op(256'd0, rand_fe(), "zero_a");
        @(negedge clk);

        // Start held high for 1000 ns: one operation only, done rises once and stays.
        a1 = 256'h79be667ef9dcbbac55a06295ce870b07029bfcdb2dce28dc9d35c49d5a3b570b;
        run_op(a1, 256'd1, 100, -10, '0, '0, e, bc, d1);
        chk(256'(e), 256'd257, "hold_latency");
        chk(bus.result, a1, "hold_identity");
        chk(256'(bc), 256'd256, "hold_busy_cycles");
        stable = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus.done !== 1'b1 || bus.busy !== 1'b0) stable = 1'b0;
        end
        chk(256'(stable), 256'd1, "hold_done_stable");

        // Start pulse during RUN is ignored; a later pulse runs the new operands.
        a1 = rand_fe();
        b1 = rand_fe();
        a2 = rand_fe();
        b2 = rand_fe();
        run_op(a1, b1, 1, 100, a2, b2, e, bc, d1);
        chk(256'(e), 256'd257, "inrun_latency");
        chk(bus.result, ref_mul(a1, b1), "inrun_first_result");
        repeat (3) @(negedge clk);
        full_op(a2, b2, "inrun_second");

        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            full_op(rand_fe(), rand_fe(), $sformatf("rand%0d", r));
        end

        // Reset mid-operation clears everything without a clock edge.
        @(negedge clk);
        bus.i_a     = rand_fe();
        bus.i_b     = rand_fe();
        bus.i_start = 1'b1;
        repeat (50) @(negedge clk);
        bus.i_start = 1'b0;
        rst_n       = 1'b0;
        #1;
        chk(bus.result, 256'd0, "midreset_result");
        chk(256'(bus.done), 256'd0, "midreset_done");
        chk(256'(bus.busy), 256'd0, "midreset_busy");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk(256'(bus.done), 256'd0, "midreset_no_flag");
        full_op(256'd5, 256'd7, "post_reset");
        chk(bus.result, 256'd35, "post_reset_const");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
